ssgd_to_bin: RTL

SSGD_TO_BIN -- requirements
Module: ssgd_to_bin

---
 rtl/ssgd_to_bin.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ssgd_to_bin.sv
// ssgd_to_bin: qualifies a two-digit active-low seven-segment display bus,
// decodes it to a 4-bit binary value, and checks that successive accepted
// values form an incrementing modulo-16 count.
//
// Data path: num -> two-flop synchronizer -> stability counter -> decoder
// -> lock/sequence FSM. Every event output is a registered single-cycle
// pulse. A pattern is accepted once, on the cycle its stability counter
// reaches STABLE_CYCLES. After that the pattern must change and settle
// again before it can be accepted a second time.

module ssgd_to_bin #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] num,
    output logic [3:0]  value,
    output logic        valid,
    output logic        seq_err,
    output logic        illegal,
    output logic        locked,
    output logic [7:0]  err_count
);

    // All segments dark on both digits.
    localparam logic [13:0] BLANK_PAT  = 14'h3FFF;
    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_PRE = 8'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Ones digit decode. Result is {ok, digit}. The code is {g,f,e,d,c,b,a},
    // active low.
    function automatic logic [4:0] decode_ones(input logic [6:0] code);
        logic [4:0] res;
        case (code)
            7'h40:   res = {1'b1, 4'd0};
            7'h79:   res = {1'b1, 4'd1};
            7'h24:   res = {1'b1, 4'd2};
            7'h30:   res = {1'b1, 4'd3};
            7'h19:   res = {1'b1, 4'd4};
            7'h12:   res = {1'b1, 4'd5};
            7'h02:   res = {1'b1, 4'd6};
            7'h78:   res = {1'b1, 4'd7};
            7'h00:   res = {1'b1, 4'd8};
            7'h10:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // Tens digit decode. Result is {ok, is_ten}. A blank tens digit reads as zero.
    function automatic logic [1:0] decode_tens(input logic [6:0] code);
        logic [1:0] res;
        case (code)
            7'h40:   res = 2'b10;
            7'h7F:   res = 2'b10;
            7'h79:   res = 2'b11;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    logic [13:0] sync1_r;
    logic [13:0] sync_r;
    logic [13:0] prev_r;
    logic [13:0] last_pat_r;
    logic [7:0]  cnt_r;
    logic        pending_r;
    state_t      state_r;
    logic [3:0]  expected_r;
    logic [3:0]  value_r;
    logic        valid_r;
    logic        seq_err_r;
    logic        illegal_r;
    logic [7:0]  err_count_r;

    logic        changed_s;
    logic        accept_s;
    logic [4:0]  ones_s;
    logic [1:0]  tens_s;
    logic [3:0]  dec_val_s;
    logic        dec_legal_s;
    logic [3:0]  next_exp_s;
    logic [7:0]  err_inc_s;

    // Two-flop synchronizer. Only the second stage feeds any logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= BLANK_PAT;
            sync_r  <= BLANK_PAT;
        end else begin
            sync1_r <= num;
            sync_r  <= sync1_r;
        end
    end

    // Acceptance condition. The pattern has held for STABLE_CYCLES cycles.
    // It is either new, or it has changed since it was last accepted.
    always_comb begin
        changed_s = 1'b0;
        accept_s  = 1'b0;
        if (sync_r != prev_r) begin
            changed_s = 1'b1;
        end else begin
            changed_s = 1'b0;
        end
        if (!changed_s && (cnt_r == STABLE_PRE) &&
            (pending_r || (sync_r != last_pat_r))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Stability counter. It restarts on any change of the synchronized
    // pattern and saturates at STABLE_CYCLES, so acceptance fires only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r    <= BLANK_PAT;
            cnt_r     <= 8'd0;
            pending_r <= 1'b0;
        end else begin
            prev_r <= sync_r;
            if (changed_s) begin
                cnt_r     <= 8'd0;
                pending_r <= 1'b1;
            end else if (cnt_r < STABLE_MAX) begin
                cnt_r <= cnt_r + 8'd1;
                if (accept_s) begin
                    pending_r <= 1'b0;
                end else begin
                    pending_r <= pending_r;
                end
            end else begin
                cnt_r     <= cnt_r;
                pending_r <= pending_r;
            end
        end
    end

    // Decode the synchronized pattern into a binary value with a legality flag.
    always_comb begin
        ones_s      = decode_ones(sync_r[6:0]);
        tens_s      = decode_tens(sync_r[13:7]);
        dec_val_s   = 4'd0;
        dec_legal_s = 1'b0;
        if (tens_s[0]) begin
            dec_val_s = ones_s[3:0] + 4'd10;
        end else begin
            dec_val_s = ones_s[3:0];
        end
        if (ones_s[4] && tens_s[1] && !(tens_s[0] && (ones_s[3:0] > 4'd5))) begin
            dec_legal_s = 1'b1;
        end else begin
            dec_legal_s = 1'b0;
        end
        next_exp_s = dec_val_s + 4'd1;
        if (err_count_r == 8'hFF) begin
            err_inc_s = err_count_r;
        end else begin
            err_inc_s = err_count_r + 8'd1;
        end
    end

    // Lock/sequence FSM. It drives registered event pulses and keeps the
    // expected-next-value tracker and the saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= UNLOCKED;
            expected_r  <= 4'd0;
            value_r     <= 4'd0;
            valid_r     <= 1'b0;
            seq_err_r   <= 1'b0;
            illegal_r   <= 1'b0;
            err_count_r <= 8'd0;
            last_pat_r  <= BLANK_PAT;
        end else begin
            valid_r   <= 1'b0;
            seq_err_r <= 1'b0;
            illegal_r <= 1'b0;
            if (accept_s) begin
                last_pat_r <= sync_r;
                if (dec_legal_s) begin
                    value_r    <= dec_val_s;
                    expected_r <= next_exp_s;
                    case (state_r)
                        UNLOCKED: begin
                            state_r <= LOCKED;
                        end
                        LOCKED: begin
                            state_r <= LOCKED;
                            if (dec_val_s == expected_r) begin
                                valid_r <= 1'b1;
                            end else begin
                                seq_err_r   <= 1'b1;
                                err_count_r <= err_inc_s;
                            end
                        end
                        default: begin
                            state_r <= UNLOCKED;
                        end
                    endcase
                end else begin
                    illegal_r   <= 1'b1;
                    err_count_r <= err_inc_s;
                    state_r     <= UNLOCKED;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign value     = value_r;
    assign valid     = valid_r;
    assign seq_err   = seq_err_r;
    assign illegal   = illegal_r;
    assign locked    = (state_r == LOCKED);
    assign err_count = err_count_r;

endmodule
